// File: rtl/program_loader.sv
// program_loader: packs a big-endian byte stream into 21-bit instruction
// words, screens the operation field, and writes accepted words into
// instruction memory at consecutive addresses while holding the CPU busy.
module program_loader #(
  parameter logic [15:0] BASE_DEFAULT = 16'h0000,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [20:0] imem_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FRAMING = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_OVERFLW = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [15:0] addr_reg;
  logic [15:0] count_reg;
  logic [15:0] last_addr;
  logic [20:0] last_data;
  logic [4:0]  op_reg;
  logic [15:0] ins_reg;
  logic [1:0]  err_reg;
  logic        start_ok;
  logic        op_ok;
  logic        write_ok;

  // Operation codes the core's decoder understands.
  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00100, 5'b01000, 5'b01100, 5'b10000,
      5'b10100, 5'b00001, 5'b00101, 5'b01001, 5'b01101,
      5'b01010, 5'b01110, 5'b01011, 5'b01111, 5'b10001,
      5'b11100, 5'b11101, 5'b11110, 5'b11001, 5'b11010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign word_count = count_reg;
  assign err_code   = err_reg;

  // State register; reset drops any load in progress back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; the write strobe is masked by reset so a
  // reset landing on the WRITE cycle never reaches memory.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    imem_we    = 1'b0;
    start_ok   = 1'b0;
    op_ok      = op_legal(op_reg);
    write_ok   = op_ok && (count_reg != MAX_W);
    case (state)
      IDLE, DONE, ERR: begin
        done = (state == DONE);
        if (start) begin
          start_ok   = 1'b1;
          state_next = B0;
        end
      end
      B0: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (rx_data == 8'hFF) begin
            state_next = DONE;
          end else if (rx_data[7:5] == 3'b000) begin
            state_next = B1;
          end else begin
            state_next = ERR;
          end
        end
      end
      B1: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          state_next = B2;
        end
      end
      B2: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        busy       = 1'b1;
        imem_we    = write_ok && !rst;
        state_next = write_ok ? B0 : ERR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    imem_addr = imem_we ? addr_reg : last_addr;
    imem_data = imem_we ? {op_reg, ins_reg} : last_data;
  end

  // Datapath: byte capture, address/count advance, error latching and the
  // held copy of the last word written.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= BASE_DEFAULT;
      count_reg <= 16'h0000;
      last_addr <= 16'h0000;
      last_data <= 21'h000000;
      op_reg    <= 5'b00000;
      ins_reg   <= 16'h0000;
      err_reg   <= ERR_NONE;
    end else begin
      if (start_ok) begin
        addr_reg  <= base_addr;
        count_reg <= 16'h0000;
        err_reg   <= ERR_NONE;
      end
      if (state == B0 && rx_valid) begin
        op_reg <= rx_data[4:0];
        if (rx_data != 8'hFF && rx_data[7:5] != 3'b000) begin
          err_reg <= ERR_FRAMING;
        end
      end
      if (state == B1 && rx_valid) begin
        ins_reg[15:8] <= rx_data;
      end
      if (state == B2 && rx_valid) begin
        ins_reg[7:0] <= rx_data;
      end
      if (state == WRITE) begin
        if (!op_ok) begin
          err_reg <= ERR_ILLEGAL;
        end else if (count_reg == MAX_W) begin
          err_reg <= ERR_OVERFLW;
        end else begin
          last_addr <= addr_reg;
          last_data <= {op_reg, ins_reg};
          addr_reg  <= addr_reg + 16'h0001;
          count_reg <= count_reg + 16'h0001;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads against two loader instances (default
// depth and a two-word depth) checked against a stream-level model.
module tb_program_loader;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          sel;
    logic [15:0] addr;
    logic [20:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [2];
  logic [15:0] base_addr  [2];
  logic [7:0]  rx_data    [2];
  logic        rx_valid   [2];
  logic        rx_ready   [2];
  logic        imem_we    [2];
  logic [15:0] imem_addr  [2];
  logic [20:0] imem_data  [2];
  logic        busy       [2];
  logic        done       [2];
  logic [1:0]  err_code   [2];
  logic [15:0] word_count [2];

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t popped;

  int unsigned legal_list [20] = '{0, 4, 8, 12, 16, 20, 1, 5, 9, 13,
                                   10, 14, 11, 15, 17, 28, 29, 30, 25, 26};

  program_loader #(.BASE_DEFAULT(16'h0000), .MAX_WORDS(1024)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .imem_we(imem_we[0]), .imem_addr(imem_addr[0]), .imem_data(imem_data[0]),
    .busy(busy[0]), .done(done[0]), .err_code(err_code[0]),
    .word_count(word_count[0])
  );

  program_loader #(.BASE_DEFAULT(16'h0000), .MAX_WORDS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .imem_we(imem_we[1]), .imem_addr(imem_addr[1]), .imem_data(imem_data[1]),
    .busy(busy[1]), .done(done[1]), .err_code(err_code[1]),
    .word_count(word_count[1])
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    foreach (legal_list[k]) begin
      if (legal_list[k] == 32'(op)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Stream-level model: walks the byte list, queues every write that must
  // appear and reports how the load must end.
  task automatic model_load(input int sel, input logic [15:0] base, input int maxw,
                            input bq_t bytes, output int consumed,
                            output logic [1:0] e_err, output logic [15:0] e_cnt,
                            output bit e_done);
    int          i;
    logic [15:0] addr;
    logic [7:0]  b;
    logic [4:0]  op;
    wr_t         w;
    i = 0; addr = base; e_err = 2'd0; e_cnt = 16'd0; e_done = 1'b0; consumed = 0;
    while (i < bytes.size()) begin
      b = bytes[i];
      if (b == 8'hFF) begin consumed = i + 1; e_done = 1'b1; return; end
      if (b[7:5] != 3'b000) begin consumed = i + 1; e_err = 2'd1; return; end
      op = b[4:0];
      consumed = i + 3;
      w.sel  = sel;
      w.addr = addr;
      w.data = {op, bytes[i+1], bytes[i+2]};
      i += 3;
      if (!is_legal(op)) begin e_err = 2'd2; return; end
      if (32'(e_cnt) == maxw) begin e_err = 2'd3; return; end
      exp_q.push_back(w);
      addr = addr + 16'd1;
      e_cnt = e_cnt + 16'd1;
    end
  endtask

  // Write monitor: every strobe must match the next write the model queued.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (imem_we[i] === 1'b1) begin
          if (exp_q.size() == 0 || exp_q[0].sel != i) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write dut%0d: addr %h data %h, no write expected",
                     i, imem_addr[i], imem_data[i]);
          end else begin
            popped = exp_q.pop_front();
            chk("write_addr", 32'(imem_addr[i]), 32'(popped.addr));
            chk("write_data", 32'(imem_data[i]), 32'(popped.data));
          end
        end
      end
    end
  end

  task automatic start_pulse(input int sel, input logic [15:0] base);
    base_addr[sel] = base;
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    rx_data[sel] = b;
    rx_valid[sel] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (rx_ready[sel]) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rx_valid[sel] = 1'b0;
  endtask

  task automatic applyStimulus(input int sel, input logic [15:0] base, input int maxw,
                               input bq_t bytes);
    int          consumed;
    logic [1:0]  e_err;
    logic [15:0] e_cnt;
    bit          e_done;
    bit          ok;
    model_load(sel, base, maxw, bytes, consumed, e_err, e_cnt, e_done);
    start_pulse(sel, base);
    #1;
    chk("start_busy", 32'(busy[sel]), 32'd1);
    chk("start_err_clear", 32'(err_code[sel]), 32'd0);
    chk("start_count_clear", 32'(word_count[sel]), 32'd0);
    for (int k = 0; k < consumed; k++) begin
      send_byte(sel, bytes[k], ok);
      if (!ok) begin
        chk("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    checkOutput(sel, e_err, e_cnt, e_done);
  endtask

  task automatic checkOutput(input int sel, input logic [1:0] e_err,
                             input logic [15:0] e_cnt, input bit e_done);
    for (int n = 0; n < 20 && busy[sel]; n++) @(negedge clk);
    #1;
    chk("end_busy", 32'(busy[sel]), 32'd0);
    chk("end_done", 32'(done[sel]), 32'(e_done));
    chk("end_err", 32'(err_code[sel]), 32'(e_err));
    chk("end_count", 32'(word_count[sel]), 32'(e_cnt));
    chk("end_rx_ready", 32'(rx_ready[sel]), 32'd0);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    bq_t         t1, t2, t2b, t3, t4, t5;
    int          c;
    logic [1:0]  e;
    logic [15:0] n;
    bit          d;
    bit          ok;

    t1  = '{8'h00, 8'h12, 8'h34, 8'h01, 8'h00, 8'h05, 8'hFF};
    t2  = '{8'h1F, 8'h00, 8'h00};
    t2b = '{8'h04, 8'hAB, 8'hCD, 8'hFF};
    t3  = '{8'h40, 8'h00, 8'h00};
    t4  = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h04, 8'h00, 8'h03, 8'hFF};
    t5  = '{8'h0A, 8'h11, 8'h22, 8'h0B, 8'h33, 8'h44, 8'hFF};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; base_addr[i] = 16'h0; rx_data[i] = 8'h0; rx_valid[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_rx_ready", 32'(rx_ready[i]), 32'd0);
      chk("reset_imem_we", 32'(imem_we[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_done", 32'(done[i]), 32'd0);
      chk("reset_err", 32'(err_code[i]), 32'd0);
      chk("reset_count", 32'(word_count[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Pin the model against hand-computed values before trusting it.
    model_load(0, 16'h0010, 1024, t1, c, e, n, d);
    chk("model_t1_addr0", 32'(exp_q[0].addr), 32'h0010);
    chk("model_t1_data0", 32'(exp_q[0].data), 32'h001234);
    chk("model_t1_addr1", 32'(exp_q[1].addr), 32'h0011);
    chk("model_t1_data1", 32'(exp_q[1].data), 32'h010005);
    chk("model_t1_count", 32'(n), 32'd2);
    exp_q.delete();
    model_load(1, 16'h0200, 2, t4, c, e, n, d);
    chk("model_t4_err", 32'(e), 32'd3);
    chk("model_t4_writes", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    model_load(0, 16'hFFFF, 1024, t5, c, e, n, d);
    chk("model_t5_wrap", 32'(exp_q[1].addr), 32'h0000);
    chk("model_t5_data1", 32'(exp_q[1].data), 32'h0B3344);
    exp_q.delete();

    $display("[TB] two-word load from 0010");
    applyStimulus(0, 16'h0010, 1024, t1);

    $display("[TB] illegal operation then clean reload");
    applyStimulus(0, 16'h0000, 1024, t2);
    applyStimulus(0, 16'h0100, 1024, t2b);

    $display("[TB] framing error");
    applyStimulus(0, 16'h0000, 1024, t3);
    rx_data[0] = 8'h00;
    rx_valid[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("err_no_accept", 32'(rx_ready[0]), 32'd0);
      chk("err_held", 32'(err_code[0]), 32'd1);
    end
    rx_valid[0] = 1'b0;

    $display("[TB] overflow with two-word depth");
    applyStimulus(1, 16'h0200, 2, t4);

    $display("[TB] address wrap");
    applyStimulus(0, 16'hFFFF, 1024, t5);

    $display("[TB] stall and reset on the handshake into WRITE");
    @(negedge clk);
    start_pulse(0, 16'h0300);
    send_byte(0, 8'h00, ok);
    send_byte(0, 8'h12, ok);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("stall_rx_ready", 32'(rx_ready[0]), 32'd1);
      chk("stall_busy", 32'(busy[0]), 32'd1);
    end
    @(negedge clk);
    rx_data[0] = 8'h34;
    rx_valid[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_imem_we", 32'(imem_we[0]), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr[0]), 32'd0);
    chk("rst_imem_data", 32'(imem_data[0]), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_err", 32'(err_code[0]), 32'd0);
    chk("rst_count", 32'(word_count[0]), 32'd0);
    rst = 1'b0;
    rx_valid[0] = 1'b0;

    $display("[TB] reset during the WRITE cycle");
    @(negedge clk);
    start_pulse(0, 16'h0400);
    send_byte(0, 8'h00, ok);
    send_byte(0, 8'h12, ok);
    send_byte(0, 8'h34, ok);
    rst = 1'b1;
    #1;
    chk("rst_write_we", 32'(imem_we[0]), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_write_count", 32'(word_count[0]), 32'd0);
    chk("rst_write_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
